// File: rtl/block_scheduler.sv
// Two-level falling-block spawn scheduler paced by synchronised VGA frame ticks.
// Optional pause (keycode 8'h13 toggle) is enabled by defining BLOCK_SCHED_PAUSE_EN.
module block_scheduler #(
  parameter int NUM_CH           = 13,
  parameter int CLK_HZ           = 50000000,
  parameter int SEC_W            = 10,
  parameter int GAP1             = 60,
  parameter int GAP2             = 30,
  parameter int SPAWNS_PER_LEVEL = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              vs,
  input  logic [7:0]        keycode,
  input  logic [NUM_CH-1:0] end_level,
  output logic [NUM_CH-1:0] block_ready,
  output logic              level_one,
  output logic              level_two,
  output logic              game_over,
  output logic              paused,
  output logic [SEC_W-1:0]  seconds
);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam int GMAX  = (GAP1 > GAP2) ? GAP1 : GAP2;
  localparam int GAP_W = $clog2(GMAX + 1);
  localparam int SPW_W = $clog2(SPAWNS_PER_LEVEL + 1);
  localparam int PRE_W = $clog2(CLK_HZ + 1);
  localparam logic [GAP_W-1:0] GLIM1   = GAP_W'(GAP1 - 1);
  localparam logic [GAP_W-1:0] GLIM2   = GAP_W'(GAP2 - 1);
  localparam logic [SPW_W-1:0] SPW_END = SPW_W'(SPAWNS_PER_LEVEL);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_SPAWN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               level_q, level_d;      // 0 = level 1, 1 = level 2
  logic [SPW_W-1:0]   spawn_q, spawn_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [NUM_CH-1:0]  br_q, br_d;
  logic               l1_q, l1_d, l2_q, l2_d, go_q, go_d, play_d;
  logic               vs_s1_q, vs_s2_q, vs_prev_q, tick;
  logic               pause_q, pause_clr;
  logic               found;
  logic [PTR_W-1:0]   cand, sel, ptr_nxt;
  int                 idx;

  assign tick = vs_s2_q & ~vs_prev_q;

  // Rotating first-free search starting at the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = PTR_W'(idx);
      if (!found && !br_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    ptr_nxt = (sel == PTR_MAX) ? '0 : sel + PTR_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      level_q   <= 1'b0;
      spawn_q   <= '0;
      gap_q     <= '0;
      ptr_q     <= '0;
      presc_q   <= '0;
      sec_q     <= '0;
      br_q      <= '0;
      l1_q      <= 1'b0;
      l2_q      <= 1'b0;
      go_q      <= 1'b0;
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      spawn_q   <= spawn_d;
      gap_q     <= gap_d;
      ptr_q     <= ptr_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      br_q      <= br_d;
      l1_q      <= l1_d;
      l2_q      <= l2_d;
      go_q      <= go_d;
      vs_s1_q   <= vs;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    spawn_d   = spawn_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    presc_d   = presc_q;
    sec_d     = sec_q;
    pause_clr = 1'b0;
    // Clears first so a set of the same channel below overrides it.
    br_d      = br_q & ~end_level;
    if ((state_q == S_GAP || state_q == S_SPAWN || state_q == S_DRAIN) && !pause_q) begin
      if (presc_q == PRE_MAX) begin
        presc_d = '0;
        if (sec_q != '1) sec_d = sec_q + SEC_W'(1);
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Run) begin
          state_d   = S_GAP;
          level_d   = 1'b0;
          spawn_d   = '0;
          gap_d     = '0;
          ptr_d     = '0;
          presc_d   = '0;
          sec_d     = '0;
          pause_clr = 1'b1;
        end
      end
      S_GAP: begin
        if (tick && !pause_q) begin
          if (gap_q == (level_q ? GLIM2 : GLIM1)) begin
            gap_d   = '0;
            state_d = S_SPAWN;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      S_SPAWN: begin
        if (found && !pause_q) begin
          br_d[sel] = 1'b1;
          ptr_d     = ptr_nxt;
          spawn_d   = spawn_q + SPW_W'(1);
          state_d   = (spawn_d == SPW_END) ? S_DRAIN : S_GAP;
        end
      end
      S_DRAIN: begin
        if (br_q == '0) begin
          if (!level_q) begin
            level_d = 1'b1;
            spawn_d = '0;
            state_d = S_GAP;
          end else begin
            state_d   = S_DONE;
            pause_clr = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    play_d = (state_d == S_GAP) || (state_d == S_SPAWN) || (state_d == S_DRAIN);
    l1_d   = play_d & ~level_d;
    l2_d   = play_d & level_d;
    go_d   = (state_d == S_DONE);
  end

`ifdef BLOCK_SCHED_PAUSE_EN
  logic [7:0] key_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q   <= '0;
      pause_q <= 1'b0;
    end else begin
      key_q <= keycode;
      if (pause_clr) pause_q <= 1'b0;
      else if (keycode == 8'h13 && key_q != 8'h13) pause_q <= ~pause_q;
    end
  end
`else
  logic unused_keycode;
  assign pause_q        = 1'b0;
  assign unused_keycode = ^{keycode, pause_clr};
`endif

  assign block_ready = br_q;
  assign level_one   = l1_q;
  assign level_two   = l2_q;
  assign game_over   = go_q;
  assign paused      = pause_q;
  assign seconds     = sec_q;
endmodule
